// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine blocks: the settings stage, this
// run-time sequencer and the machine top level.
//   WM_MIN_W  width of one per-phase minute count
//   WM_TOT_W  width of the whole-cycle minute count
//   WM_PH_*   3-bit phase encoding seen on the phase output
package wm_pkg;
    localparam int WM_MIN_W = 5;
    localparam int WM_TOT_W = 8;

    localparam logic [2:0] WM_PH_IDLE   = 3'd0;
    localparam logic [2:0] WM_PH_FILL   = 3'd1;
    localparam logic [2:0] WM_PH_WASH   = 3'd2;
    localparam logic [2:0] WM_PH_DRAIN1 = 3'd3;
    localparam logic [2:0] WM_PH_RINSE  = 3'd4;
    localparam logic [2:0] WM_PH_DRAIN2 = 3'd5;
    localparam logic [2:0] WM_PH_SPIN   = 3'd6;
    localparam logic [2:0] WM_PH_DONE   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = WM_PH_IDLE,
        ST_FILL   = WM_PH_FILL,
        ST_WASH   = WM_PH_WASH,
        ST_DRAIN1 = WM_PH_DRAIN1,
        ST_RINSE  = WM_PH_RINSE,
        ST_DRAIN2 = WM_PH_DRAIN2,
        ST_SPIN   = WM_PH_SPIN,
        ST_DONE   = WM_PH_DONE
    } wm_phase_e;
endpackage

// File: rtl/wm_cycle_sequencer_if.sv
// Bundle between the cycle sequencer and its controller.
//   master: drives start/pause/abort/door_closed and the three minute settings,
//           observes phase, counters, status and actuator enables.
//   slave : the sequencer side (directions reversed).
interface wm_cycle_sequencer_if;
    import wm_pkg::*;

    logic                start;
    logic                pause;
    logic                abort;
    logic                door_closed;
    logic [WM_MIN_W-1:0] wash_min;
    logic [WM_MIN_W-1:0] rinse_min;
    logic [WM_MIN_W-1:0] spin_min;

    logic [2:0]          phase;
    logic [WM_MIN_W-1:0] phase_left;
    logic [WM_TOT_W-1:0] total_left;
    logic                busy;
    logic                done;
    logic                valve_in;
    logic                drum_motor;
    logic                pump;
    logic                spin_motor;
    logic                door_lock;

    modport master (
        output start, pause, abort, door_closed, wash_min, rinse_min, spin_min,
        input  phase, phase_left, total_left, busy, done,
               valve_in, drum_motor, pump, spin_motor, door_lock
    );

    modport slave (
        input  start, pause, abort, door_closed, wash_min, rinse_min, spin_min,
        output phase, phase_left, total_left, busy, done,
               valve_in, drum_motor, pump, spin_motor, door_lock
    );
endinterface

// File: rtl/wm_minute_tick.sv
// Minute prescaler: counts 0..TICKS_PER_MIN-1 and flags the last count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count back to 0 (wins over hold)
//   hold       : freeze the count and suppress tick
//   tick       : high during the cycle whose rising edge ends a minute
module wm_minute_tick #(
    parameter int TICKS_PER_MIN = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int CNT_W = $clog2(TICKS_PER_MIN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MIN - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (!hold) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign tick = (count_reg == LAST) && !hold;
endmodule

// File: rtl/wm_cycle_sequencer.sv
// Washing-machine run-time sequencer. Latches the wash/rinse/spin minutes on
// start and steps FILL->WASH->DRAIN1->RINSE->DRAIN2->SPIN->DONE on minute
// ticks, skipping zero-length phases, while counting down phase and total
// minutes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wm_cycle_sequencer_if.slave (controls, settings, status,
//                actuator enables)
module wm_cycle_sequencer
    import wm_pkg::*;
#(
    parameter int TICKS_PER_MIN = 60,
    parameter int FILL_MIN      = 2,
    parameter int DRAIN_MIN     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wm_cycle_sequencer_if.slave  bus
);
    localparam logic [WM_MIN_W-1:0] FILL_LEN  = WM_MIN_W'(FILL_MIN);
    localparam logic [WM_MIN_W-1:0] DRAIN_LEN = WM_MIN_W'(DRAIN_MIN);
    localparam logic [WM_TOT_W-1:0] FIXED_TOT = WM_TOT_W'(FILL_MIN + 2 * DRAIN_MIN);

    wm_phase_e           phase_reg, phase_next, adv_phase;
    logic [WM_MIN_W-1:0] phase_left_reg, phase_left_next, adv_left;
    logic [WM_TOT_W-1:0] total_left_reg, total_left_next;
    logic [WM_MIN_W-1:0] wash_reg, wash_next, rinse_reg, rinse_next, spin_reg, spin_next;
    logic                valve_reg, valve_next, drum_reg, drum_next;
    logic                pump_reg, pump_next, spin_motor_reg, spin_motor_next;
    logic                busy_w, kill_w, hold_w, tick_w;

    assign busy_w = (phase_reg != ST_IDLE) && (phase_reg != ST_DONE);
    // Abort or an opened door beats pause; pause only matters mid-cycle.
    assign kill_w = busy_w && (bus.abort || !bus.door_closed);
    assign hold_w = busy_w && bus.pause && !kill_w;

    // Prescaler is kept cleared outside the cycle, so it starts from 0 on accept.
    wm_minute_tick #(.TICKS_PER_MIN(TICKS_PER_MIN)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!busy_w || kill_w),
        .hold  (bus.pause),
        .tick  (tick_w)
    );

    // Next non-empty phase after the current one, and its length.
    always_comb begin
        adv_phase = ST_DONE;
        unique case (phase_reg)
            ST_FILL:   adv_phase = (wash_reg  != '0) ? ST_WASH  : ST_DRAIN1;
            ST_WASH:   adv_phase = ST_DRAIN1;
            ST_DRAIN1: adv_phase = (rinse_reg != '0) ? ST_RINSE : ST_DRAIN2;
            ST_RINSE:  adv_phase = ST_DRAIN2;
            ST_DRAIN2: adv_phase = (spin_reg  != '0) ? ST_SPIN  : ST_DONE;
            default:   adv_phase = ST_DONE;
        endcase
        adv_left = '0;
        unique case (adv_phase)
            ST_WASH:              adv_left = wash_reg;
            ST_DRAIN1, ST_DRAIN2: adv_left = DRAIN_LEN;
            ST_RINSE:             adv_left = rinse_reg;
            ST_SPIN:              adv_left = spin_reg;
            default:              adv_left = '0;
        endcase
    end

    always_comb begin
        phase_next      = phase_reg;
        phase_left_next = phase_left_reg;
        total_left_next = total_left_reg;
        wash_next       = wash_reg;
        rinse_next      = rinse_reg;
        spin_next       = spin_reg;

        if (kill_w) begin
            phase_next      = ST_IDLE;
            phase_left_next = '0;
            total_left_next = '0;
        end else if (hold_w) begin
            // everything holds
        end else if (busy_w && tick_w) begin
            total_left_next = total_left_reg - 1'b1;
            if (phase_left_reg == WM_MIN_W'(1)) begin
                phase_next      = adv_phase;
                phase_left_next = adv_left;
            end else begin
                phase_left_next = phase_left_reg - 1'b1;
            end
        end else if (phase_reg == ST_DONE) begin
            phase_next      = ST_IDLE;
            phase_left_next = '0;
            total_left_next = '0;
        end else if (phase_reg == ST_IDLE && bus.start && bus.door_closed && !bus.abort) begin
            wash_next       = bus.wash_min;
            rinse_next      = bus.rinse_min;
            spin_next       = bus.spin_min;
            phase_next      = ST_FILL;
            phase_left_next = FILL_LEN;
            total_left_next = FIXED_TOT + WM_TOT_W'(bus.wash_min)
                            + WM_TOT_W'(bus.rinse_min) + WM_TOT_W'(bus.spin_min);
        end

        // Actuators are registered from the next phase so they never glitch;
        // a paused edge turns them all off for the following cycle.
        valve_next      = !hold_w && (phase_next == ST_FILL);
        drum_next       = !hold_w && (phase_next == ST_WASH || phase_next == ST_RINSE);
        pump_next       = !hold_w && (phase_next == ST_DRAIN1 || phase_next == ST_DRAIN2
                                      || phase_next == ST_SPIN);
        spin_motor_next = !hold_w && (phase_next == ST_SPIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg      <= ST_IDLE;
            phase_left_reg <= '0;
            total_left_reg <= '0;
            wash_reg       <= '0;
            rinse_reg      <= '0;
            spin_reg       <= '0;
            valve_reg      <= 1'b0;
            drum_reg       <= 1'b0;
            pump_reg       <= 1'b0;
            spin_motor_reg <= 1'b0;
        end else begin
            phase_reg      <= phase_next;
            phase_left_reg <= phase_left_next;
            total_left_reg <= total_left_next;
            wash_reg       <= wash_next;
            rinse_reg      <= rinse_next;
            spin_reg       <= spin_next;
            valve_reg      <= valve_next;
            drum_reg       <= drum_next;
            pump_reg       <= pump_next;
            spin_motor_reg <= spin_motor_next;
        end
    end

    assign bus.phase      = phase_reg;
    assign bus.phase_left = phase_left_reg;
    assign bus.total_left = total_left_reg;
    assign bus.busy       = busy_w;
    assign bus.done       = (phase_reg == ST_DONE);
    assign bus.door_lock  = busy_w;
    assign bus.valve_in   = valve_reg;
    assign bus.drum_motor = drum_reg;
    assign bus.pump       = pump_reg;
    assign bus.spin_motor = spin_motor_reg;
endmodule
